// File: rtl/spi_regbank.sv
// spi_regbank: SPI slave exposing NREG control and NREG status registers.
// All SPI pins are oversampled in the clk_i domain; there is no SCK-domain logic.
// Frame (MSB first): W bit, ADDR_W address bits, DATA_W data bits.
// Optional burst mode, enabled by defining SPI_REGBANK_AUTOINC_EN: after each data
// word the address increments (wrapping) and further words continue the transfer.
module spi_regbank #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 3,
  parameter bit                CPOL        = 1'b0,
  parameter bit                CPHA        = 1'b0,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] CTRL_RST    = '0
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               nss_i,
  input  logic                               sck_i,
  input  logic                               sdi_i,
  output logic                               sdo_o,
  input  logic [(2**ADDR_W)*DATA_W-1:0]      stat_i,
  output logic [(2**ADDR_W)*DATA_W-1:0]      ctrl_o,
  output logic [(2**ADDR_W)-1:0]             wr_stb_o,
  output logic                               busy_o,
  output logic                               frame_err_o
);

  localparam int NREG    = 2**ADDR_W;
  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] HDR       = CNT_W'(ADDR_W + 1);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(FRAME_W);

`ifdef SPI_REGBANK_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] nss_sync_q, sck_sync_q, sdi_sync_q;
  logic                   nss_dly_q, sck_dly_q;

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   w_q, w_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      rx_q, rx_d;
  logic [DATA_W-1:0]      tx_q, tx_d;
  logic [NREG*DATA_W-1:0] ctrl_q, ctrl_d;
  logic [NREG-1:0]        wr_stb_q, wr_stb_d;
  logic                   sdo_q, sdo_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;

  logic              nss_s, sck_s, sdi_s;
  logic              nss_fall, nss_rise, lead_edge, trail_edge, sample_edge, shift_edge;
  logic [ADDR_W:0]   addr_shift;
  logic [ADDR_W-1:0] addr_in, addr_inc;
  logic [DATA_W-1:0] rx_word;

  assign nss_s = nss_sync_q[SYNC_STAGES-1];
  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

  assign nss_fall    = nss_dly_q & ~nss_s;
  assign nss_rise    = ~nss_dly_q & nss_s;
  assign lead_edge   = (sck_dly_q == CPOL) && (sck_s != CPOL);
  assign trail_edge  = (sck_dly_q != CPOL) && (sck_s == CPOL);
  assign sample_edge = busy_q && (CPHA ? trail_edge : lead_edge);
  assign shift_edge  = busy_q && (CPHA ? lead_edge : trail_edge);

  assign addr_shift = {addr_q, sdi_s};
  assign addr_in    = addr_shift[ADDR_W-1:0];
  assign addr_inc   = addr_q + ADDR_W'(1);
  assign rx_word    = {rx_q[DATA_W-2:0], sdi_s};

  // Synchronise the SPI pins; nss resets low so a select already held low at
  // reset release never looks like a frame start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nss_sync_q <= '0;
      sck_sync_q <= {SYNC_STAGES{CPOL}};
      sdi_sync_q <= '0;
      nss_dly_q  <= 1'b0;
      sck_dly_q  <= CPOL;
    end else begin
      nss_sync_q <= {nss_sync_q[SYNC_STAGES-2:0], nss_i};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
      nss_dly_q  <= nss_s;
      sck_dly_q  <= sck_s;
    end
  end

  // Frame sequencing: bit counting, address/data capture, register update and MISO shifting.
  always_comb begin
    cnt_d    = cnt_q;
    w_d      = w_q;
    addr_d   = addr_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    ctrl_d   = ctrl_q;
    wr_stb_d = '0;
    sdo_d    = sdo_q;
    busy_d   = busy_q;
    err_d    = 1'b0;
    done_d   = done_q;
    if (nss_fall) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      w_d    = 1'b0;
      addr_d = '0;
      rx_d   = '0;
      tx_d   = '0;
      done_d = 1'b0;
      sdo_d  = 1'b0;
    end else if (busy_q) begin
      if (sample_edge) begin
        rx_d = rx_word;
        if (cnt_q == '0) begin
          w_d   = sdi_s;
          cnt_d = cnt_q + CNT_W'(1);
        end else if (cnt_q <= ADDR_LAST) begin
          addr_d = addr_in;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == ADDR_LAST) tx_d = stat_i[addr_in*DATA_W +: DATA_W];
        end else if (cnt_q < FULL) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            done_d = 1'b1;
            if (w_q) begin
              ctrl_d[addr_q*DATA_W +: DATA_W] = rx_word;
              wr_stb_d[addr_q]                = 1'b1;
            end
            if (AUTOINC) begin
              addr_d = addr_inc;
              cnt_d  = HDR;
              tx_d   = stat_i[addr_inc*DATA_W +: DATA_W];
            end
          end
        end
      end
      if (shift_edge) begin
        if (!w_q && cnt_q >= HDR && cnt_q < FULL) begin
          sdo_d = tx_q[DATA_W-1];
          tx_d  = {tx_q[DATA_W-2:0], 1'b0};
        end else begin
          sdo_d = 1'b0;
        end
      end
      // A sample landing in the rise cycle is already folded into cnt_d/done_d,
      // so a word completing together with nss rising is not an error.
      if (nss_rise) begin
        busy_d = 1'b0;
        sdo_d  = 1'b0;
        if (AUTOINC) err_d = (cnt_d != '0) && !(done_d && cnt_d == HDR);
        else         err_d = (cnt_d != '0) && (cnt_d != FULL);
        cnt_d  = '0;
      end
    end
  end

  // Frame state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      w_q      <= 1'b0;
      addr_q   <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      ctrl_q   <= {NREG{CTRL_RST}};
      wr_stb_q <= '0;
      sdo_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      w_q      <= w_d;
      addr_q   <= addr_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      ctrl_q   <= ctrl_d;
      wr_stb_q <= wr_stb_d;
      sdo_q    <= sdo_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign sdo_o       = sdo_q;
  assign ctrl_o      = ctrl_q;
  assign wr_stb_o    = wr_stb_q;
  assign busy_o      = busy_q;
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Testbench for spi_regbank: one instance per CPOL/CPHA mode, a bit-banged SPI master,
// a strobe monitor feeding a scoreboard and a table of write/read vectors.
module tb_spi_regbank;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int BW   = NREG * DW;
  localparam int H    = 60;   // SCK half period in ns (6 clk_i cycles)

  typedef struct {
    int          m;
    bit          w;
    logic [2:0]  addr;
    logic [15:0] data;
  } vec_t;

  typedef struct {
    int          m;
    logic [7:0]  stb;
    logic [BW-1:0] ctrl;
  } exp_t;

  typedef struct {
    int          m;
    logic [7:0]  stb;
    logic [BW-1:0] ctrl;
    bit          b2b;
  } act_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          nss_b   [4];
  logic          sck_b   [4];
  logic          sdi_b   [4];
  logic          sdo_b   [4];
  logic [BW-1:0] ctrl_b  [4];
  logic [7:0]    wr_stb_b[4];
  logic          busy_b  [4];
  logic          err_b   [4];
  logic [BW-1:0] stat;

  int            n_cmp  = 0;
  int            n_fail = 0;

  exp_t          exp_q[$];
  logic [15:0]   rd_exp_q[$];
  act_t          act_a[256];
  int            act_wr = 0;
  int            act_rd = 0;
  int            err_cnt[4] = '{0, 0, 0, 0};
  logic [7:0]    prev_stb[4] = '{8'h0, 8'h0, 8'h0, 8'h0};
  logic [BW-1:0] model[4];
  vec_t          vecs[14];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_regbank #(
      .CPOL(1'(g / 2)),
      .CPHA(1'(g % 2))
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .nss_i      (nss_b[g]),
      .sck_i      (sck_b[g]),
      .sdi_i      (sdi_b[g]),
      .sdo_o      (sdo_b[g]),
      .stat_i     (stat),
      .ctrl_o     (ctrl_b[g]),
      .wr_stb_o   (wr_stb_b[g]),
      .busy_o     (busy_b[g]),
      .frame_err_o(err_b[g])
    );
  end

  // Monitor: records every strobe cycle and counts frame_err cycles per instance.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (wr_stb_b[g] != 8'h0 && act_wr < 256) begin
        act_a[act_wr].m    = g;
        act_a[act_wr].stb  = wr_stb_b[g];
        act_a[act_wr].ctrl = ctrl_b[g];
        act_a[act_wr].b2b  = (prev_stb[g] != 8'h0);
        act_wr++;
      end
      if (err_b[g]) err_cnt[g]++;
      prev_stb[g] = wr_stb_b[g];
    end
  end

  initial begin
    #(2ms);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic spi_xfer(input int m, input logic [35:0] bits, input int nbits,
                          input bit chk_busy, input int exp_err, output logic [35:0] miso);
    bit cpol, cpha;
    int e0;
    cpol = (m / 2) == 1;
    cpha = (m % 2) == 1;
    miso = '0;
    e0   = err_cnt[m];
    nss_b[m] = 1'b0;
    #(H);
    if (chk_busy) chk("busy_in_frame", BW'(busy_b[m]), BW'(1));
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        sdi_b[m] = bits[nbits-1-i];
        #(H);
        sck_b[m] = ~cpol;
        miso[nbits-1-i] = sdo_b[m];
        #(H);
        sck_b[m] = cpol;
      end else begin
        sck_b[m] = ~cpol;
        sdi_b[m] = bits[nbits-1-i];
        #(H);
        sck_b[m] = cpol;
        miso[nbits-1-i] = sdo_b[m];
        #(H);
      end
    end
    #(H);
    nss_b[m] = 1'b1;
    #(2*H);
    if (chk_busy) chk("busy_after_frame", BW'(busy_b[m]), BW'(0));
    chk("frame_err_pulses", BW'(err_cnt[m] - e0), BW'(exp_err));
    chk("sdo_idle", BW'(sdo_b[m]), BW'(0));
  endtask

  task automatic drain();
    exp_t e;
    while (act_rd < act_wr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", BW'(act_a[act_rd].stb), BW'(0));
      end else begin
        e = exp_q.pop_front();
        chk("strobe_inst", BW'(act_a[act_rd].m), BW'(e.m));
        chk("strobe_mask", BW'(act_a[act_rd].stb), BW'(e.stb));
        chk("strobe_ctrl", act_a[act_rd].ctrl, e.ctrl);
        chk("strobe_width", BW'(act_a[act_rd].b2b), BW'(0));
      end
      act_rd++;
    end
    chk("missing_strobes", BW'(exp_q.size()), BW'(0));
    exp_q.delete();
  endtask

  task automatic push_write(input int m, input logic [2:0] addr, input logic [15:0] data);
    exp_t e;
    model[m][addr*DW +: DW] = data;
    e.m    = m;
    e.stb  = 8'(8'd1 << addr);
    e.ctrl = model[m];
    exp_q.push_back(e);
  endtask

  task automatic do_write(input int m, input logic [2:0] addr, input logic [15:0] data);
    logic [35:0] miso;
    push_write(m, addr, data);
    spi_xfer(m, 36'({1'b1, addr, data}), 20, 1'b1, 0, miso);
    drain();
  endtask

  task automatic do_read(input int m, input logic [2:0] addr, input logic [15:0] sval);
    logic [35:0] miso;
    logic [15:0] exp_rd;
    stat[addr*DW +: DW] = sval;
    rd_exp_q.push_back(sval);
    spi_xfer(m, 36'({1'b0, addr, 16'h0}), 20, 1'b1, 0, miso);
    exp_rd = rd_exp_q.pop_front();
    chk("read_data", BW'(miso[15:0]), BW'(exp_rd));
    chk("read_keeps_ctrl", ctrl_b[m], model[m]);
    drain();
  endtask

  initial begin
    logic [35:0] miso;
    logic [15:0] exp_rd;

    vecs[0]  = '{0, 1'b1, 3'd5, 16'hA55A};
    vecs[1]  = '{0, 1'b0, 3'd2, 16'h1234};
    vecs[2]  = '{0, 1'b1, 3'd7, 16'hC3C3};
    vecs[3]  = '{0, 1'b0, 3'd7, 16'h0F0F};
    vecs[4]  = '{1, 1'b1, 3'd7, 16'hC3C3};
    vecs[5]  = '{1, 1'b0, 3'd7, 16'h0F0F};
    vecs[6]  = '{2, 1'b1, 3'd7, 16'hC3C3};
    vecs[7]  = '{2, 1'b0, 3'd7, 16'h0F0F};
    vecs[8]  = '{3, 1'b1, 3'd7, 16'hC3C3};
    vecs[9]  = '{3, 1'b0, 3'd7, 16'h0F0F};
    vecs[10] = '{1, 1'b1, 3'd0, 16'hFFFF};
    vecs[11] = '{2, 1'b0, 3'd0, 16'h8001};
    vecs[12] = '{3, 1'b1, 3'd2, 16'h0001};
    vecs[13] = '{3, 1'b0, 3'd6, 16'hFFFE};

    rst  = 1'b1;
    stat = '0;
    for (int m = 0; m < 4; m++) begin
      nss_b[m] = 1'b1;
      sck_b[m] = (m / 2) == 1;
      sdi_b[m] = 1'b0;
      model[m] = '0;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #(100);

    for (int m = 0; m < 4; m++) begin
      chk("reset_ctrl", ctrl_b[m], '0);
      chk("reset_outputs", BW'({sdo_b[m], busy_b[m], err_b[m], wr_stb_b[m]}), BW'(0));
    end

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].w) do_write(vecs[i].m, vecs[i].addr, vecs[i].data);
      else           do_read(vecs[i].m, vecs[i].addr, vecs[i].data);
    end

    // Status snapshot is taken once per word: a mid-word change must not show up.
    stat[4*DW +: DW] = 16'hBEEF;
    rd_exp_q.push_back(16'hBEEF);
    fork
      spi_xfer(0, 36'({1'b0, 3'd4, 16'h0}), 20, 1'b1, 0, miso);
      begin
        #(H + 10*2*H);
        stat[4*DW +: DW] = 16'h0000;
      end
    join
    exp_rd = rd_exp_q.pop_front();
    chk("snapshot_read", BW'(miso[15:0]), BW'(exp_rd));
    drain();

    // Select pulse with no clocks: no error, no strobe.
    spi_xfer(0, 36'h0, 0, 1'b1, 0, miso);
    drain();

    // Abort after 10 of 20 bits of a write to reg1.
    spi_xfer(0, 36'({1'b1, 3'd1, 16'hBEEF}) >> 10, 10, 1'b1, 1, miso);
    chk("abort_keeps_reg1", BW'(ctrl_b[0][1*DW +: DW]), BW'(16'h0000));
    drain();
    do_write(0, 3'd1, 16'h1357);

    // Reset mid-write discards the frame and restores every control register.
    do_write(0, 3'd3, 16'h00FF);
    fork
      spi_xfer(0, 36'({1'b1, 3'd3, 16'h1234}), 20, 1'b0, 0, miso);
      begin
        #(H + 7*2*H);
        rst = 1'b1;
        #(30);
        rst = 1'b0;
      end
    join
    for (int m = 0; m < 4; m++) begin
      model[m] = '0;
      chk("reset_mid_frame_ctrl", ctrl_b[m], '0);
    end
    chk("reset_mid_frame_sdo", BW'(sdo_b[0]), BW'(0));
    drain();
    do_write(0, 3'd3, 16'h0A0A);

`ifdef SPI_REGBANK_AUTOINC_EN
    // Burst write wrapping from reg7 to reg0.
    push_write(0, 3'd7, 16'h1111);
    push_write(0, 3'd0, 16'h2222);
    spi_xfer(0, {1'b1, 3'd7, 16'h1111, 16'h2222}, 36, 1'b1, 0, miso);
    drain();
`else
    // Bits past the end of the frame are ignored without error.
    push_write(0, 3'd6, 16'h6789);
    spi_xfer(0, 36'({1'b1, 3'd6, 16'h6789, 4'hF}), 24, 1'b1, 0, miso);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
